// File: rtl/hostaddr_lookup_ctrl_if.sv
// hostaddr_lookup_ctrl_if
// Bundles every signal between the host-address lookup controller and its
// neighbours: the config writer, the parser lookup requester and the table RAM.
//   cfg_wr_*  : config write request (valid/ready, addr, data)
//   lk_*      : lookup request (valid/ready, key[, mask]) and result (done/hit/index)
//   ram_*     : table RAM data/addr/we driven by the controller, q returned by the RAM
// Modports: slave = the controller, master = requesters plus RAM.
// Optional feature macro HOSTADDR_LOOKUP_MASK_EN adds the lk_mask signal.
interface hostaddr_lookup_ctrl_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 80
);
    logic                  cfg_wr_valid;
    logic                  cfg_wr_ready;
    logic [ADDR_WIDTH-1:0] cfg_wr_addr;
    logic [DATA_WIDTH-1:0] cfg_wr_data;

    logic                  lk_valid;
    logic                  lk_ready;
    logic [DATA_WIDTH-1:0] lk_key;
`ifdef HOSTADDR_LOOKUP_MASK_EN
    logic [DATA_WIDTH-1:0] lk_mask;
`endif
    logic                  lk_done;
    logic                  lk_hit;
    logic [ADDR_WIDTH-1:0] lk_index;

    logic [DATA_WIDTH-1:0] ram_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
        output cfg_wr_ready,
        input  lk_valid, lk_key,
`ifdef HOSTADDR_LOOKUP_MASK_EN
        input  lk_mask,
`endif
        output lk_ready, lk_done, lk_hit, lk_index,
        output ram_data, ram_addr, ram_we,
        input  ram_q
    );

    modport master (
        output cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
        input  cfg_wr_ready,
        output lk_valid, lk_key,
`ifdef HOSTADDR_LOOKUP_MASK_EN
        output lk_mask,
`endif
        input  lk_ready, lk_done, lk_hit, lk_index,
        input  ram_data, ram_addr, ram_we,
        output ram_q
    );
endinterface

// File: rtl/hostaddr_lookup_ctrl.sv
// hostaddr_lookup_ctrl
// Sole owner of the host-address table RAM (synchronous write, registered
// address read with one cycle of latency). In IDLE it forwards config writes
// straight to the RAM; a lookup request latches its key and scans every entry,
// returning the first matching index.
// Ports:
//   clk    : clock, all logic on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : hostaddr_lookup_ctrl_if.slave (config write, lookup, RAM signals)
// Optional feature macro HOSTADDR_LOOKUP_MASK_EN: a per-lookup mask is latched
// with the key and only the masked bits take part in the compare.
module hostaddr_lookup_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 80
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hostaddr_lookup_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] scanCount_q, scanCount_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
`ifdef HOSTADDR_LOOKUP_MASK_EN
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
`endif
    logic                  tagValid_q, tagValid_d;
    logic [ADDR_WIDTH-1:0] tagIndex_q, tagIndex_d;
    logic                  done_q, done_d;
    logic                  hit_q, hit_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;

    logic accept;
    logic tagMatch;
    logic finish;

    // Config write wins a same-cycle conflict, so a lookup is only taken
    // when no write is pending.
    assign accept = (state_q == IDLE) && bus.lk_valid && !bus.cfg_wr_valid;

    // The tag marks that ram_q holds the entry addressed one cycle earlier.
`ifdef HOSTADDR_LOOKUP_MASK_EN
    assign tagMatch = tagValid_q && (((bus.ram_q ^ key_q) & mask_q) == '0);
`else
    assign tagMatch = tagValid_q && (bus.ram_q == key_q);
`endif

    // DRAIN always resolves the lookup: either the last entry hits or it misses.
    assign finish = ((state_q == SCAN) && tagMatch) || (state_q == DRAIN);

    assign bus.lk_done  = done_q;
    assign bus.lk_hit   = hit_q;
    assign bus.lk_index = index_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scanCount_q <= '0;
            key_q       <= '0;
`ifdef HOSTADDR_LOOKUP_MASK_EN
            mask_q      <= '0;
`endif
            tagValid_q  <= 1'b0;
            tagIndex_q  <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            scanCount_q <= scanCount_d;
            key_q       <= key_d;
`ifdef HOSTADDR_LOOKUP_MASK_EN
            mask_q      <= mask_d;
`endif
            tagValid_q  <= tagValid_d;
            tagIndex_q  <= tagIndex_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            index_q     <= index_d;
        end
    end

    // Next state: walk the counter through every entry, leave early on the
    // first tagged match, and spend one DRAIN cycle comparing the last entry.
    always_comb begin
        state_d     = state_q;
        scanCount_d = scanCount_q;
        key_d       = key_q;
`ifdef HOSTADDR_LOOKUP_MASK_EN
        mask_d      = mask_q;
`endif
        tagValid_d  = (state_q == SCAN);
        tagIndex_d  = scanCount_q;
        done_d      = finish;
        hit_d       = hit_q;
        index_d     = index_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SCAN;
                    scanCount_d = '0;
                    key_d       = bus.lk_key;
`ifdef HOSTADDR_LOOKUP_MASK_EN
                    mask_d      = bus.lk_mask;
`endif
                end
            end
            SCAN: begin
                scanCount_d = scanCount_q + ADDR_WIDTH'(1);
                if (tagMatch) begin
                    state_d = IDLE;
                end else if (scanCount_q == LAST_INDEX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result registers only move when a lookup resolves, so they hold
        // between lk_done pulses.
        if (finish) begin
            hit_d   = tagMatch;
            index_d = tagMatch ? tagIndex_q : '0;
        end
    end

    // Outputs: handshakes and RAM port. Writes can only happen in IDLE,
    // which keeps the table stable for the whole scan.
    always_comb begin
        bus.cfg_wr_ready = 1'b0;
        bus.lk_ready     = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = '0;
        bus.ram_data     = '0;

        case (state_q)
            IDLE: begin
                bus.cfg_wr_ready = 1'b1;
                bus.lk_ready     = !bus.cfg_wr_valid;
                bus.ram_we       = bus.cfg_wr_valid;
                bus.ram_addr     = bus.cfg_wr_addr;
                bus.ram_data     = bus.cfg_wr_data;
            end
            SCAN, DRAIN: begin
                bus.ram_addr = scanCount_q;
            end
            default: begin
                bus.ram_addr = '0;
            end
        endcase

        // Keep the RAM quiet while reset is held, whatever the requesters do.
        if (!rst_n) begin
            bus.ram_we   = 1'b0;
            bus.ram_addr = '0;
        end
    end
endmodule

// File: doc/hostaddr_lookup_ctrl.md
Name: hostaddr_lookup_ctrl

Overview:
Controller that owns the host-address table RAM. The RAM has a synchronous write and a registered-address read with 1-cycle latency. The block shares the RAM between two requesters: the config writer, which loads entries, and the parser lookup, which scans every entry for a key and returns the first matching index. It sits between the FIX parser value path and the table RAM, and it is the only driver of the RAM's data/addr/we inputs.

Parameters:
ADDR_WIDTH, `HOST_ADDR_WIDTH (2), table address width; DEPTH = 1 << ADDR_WIDTH
DATA_WIDTH, `VALUE_DATA_WIDTH + `VALUE_SIZE (80), entry width

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
cfg_wr_valid  in  1  config write request
cfg_wr_ready  out  1  config write accepted when valid&ready
cfg_wr_addr  in  ADDR_WIDTH  entry index to write
cfg_wr_data  in  DATA_WIDTH  entry value
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted when valid&ready
lk_key  in  DATA_WIDTH  value to search for
lk_done  out  1  one-cycle pulse, lookup result valid
lk_hit  out  1  1 = match found
lk_index  out  ADDR_WIDTH  first matching index; 0 on miss
ram_data  out  DATA_WIDTH  to RAM data
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_we  out  1  to RAM we
ram_q  in  DATA_WIDTH  from RAM q

Behaviour:
- Reset (async, rst_n=0): state IDLE; scan counter 0; key register 0; lk_done=0, lk_hit=0, lk_index=0. ram_we=0 and ram_addr=0 while in reset. cfg_wr_ready/lk_ready follow the state rules below, so both can be high immediately after reset.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - cfg_wr_ready=1.
  - lk_ready = !cfg_wr_valid. Config write has priority on a same-cycle conflict.
  - Config write: ram_we=cfg_wr_valid, ram_addr=cfg_wr_addr, ram_data=cfg_wr_data. Single cycle, state stays IDLE.
  - Lookup accept: latch lk_key, counter<=0, go to SCAN.
- SCAN:
  - cfg_wr_ready=0 and lk_ready=0. ram_we=0.
  - ram_addr=counter; counter increments each cycle.
  - Compare pipeline: a 1-cycle-delayed valid/index tag marks that ram_q holds entry (counter-1). The compare is ram_q == key.
  - When counter reaches DEPTH-1 and has been issued, go to DRAIN.
  - On a tagged match in SCAN or DRAIN: register lk_hit=1 and lk_index=tag; pulse lk_done next cycle; go to IDLE. Addresses issued after the match are discarded; reads are harmless.
- DRAIN: compares the last entry. On match, behave as the hit case. On no match: lk_done=1, lk_hit=0, lk_index=0, go to IDLE.
- Timing, with accept in cycle 0:
  - Entry i is addressed in cycle i+1 and compared in cycle i+2.
  - Hit on entry i: lk_done in cycle i+3.
  - Miss: lk_done in cycle DEPTH+2.
- Next lookup can be accepted in the lk_done cycle, because state is IDLE then.
- lk_hit and lk_index hold until the next lk_done. lk_done is high for exactly one cycle.
- No write is ever issued while in SCAN or DRAIN, so the table is coherent for the whole scan.
- Reset mid-scan aborts the lookup: no lk_done, outputs return to reset values.
- cfg_wr_addr wraps naturally at DEPTH; there is no range error.

Optional Feature:
- Macro: HOSTADDR_LOOKUP_MASK_EN.
- When defined:
  - Adds input port lk_mask [DATA_WIDTH-1:0], latched with lk_key at accept.
  - Match becomes (ram_q & mask) == (key & mask).
  - An all-zero mask matches entry 0 (lk_done in cycle 3).
- When undefined: port absent; full-width equality only.

Test Plan:
- Preload entries 0,2,3=80'h6f726465726d61746368 and 1=80'h63686f726465726d6174; lookup key 80'h63686f726465726d6174 -> lk_done in cycle 4 after accept, lk_hit=1, lk_index=1.
- Same table, key 80'h6f726465726d61746368 -> lk_done in cycle 3, lk_hit=1, lk_index=0 (first match wins over 2 and 3).
- Key 80'h0 -> lk_done in cycle 6 (DEPTH=4), lk_hit=0, lk_index=0. Exactly one lk_done pulse.
- Config write addr 3 data 80'h00000000000000000001, then key 80'h1 -> ram_we high for one cycle at addr 3; lookup returns hit, index 3, done in cycle 6.
- cfg_wr_valid and lk_valid asserted together in IDLE -> write done that cycle with lk_ready=0. Lookup accepted next cycle. A cfg_wr_valid held during the scan sees cfg_wr_ready=0 until the lk_done cycle and ram_we is never asserted in SCAN/DRAIN.
- Assert rst_n=0 in cycle 2 of a scan -> no lk_done pulse; lk_hit=0, lk_index=0, lk_ready=1 after release. A new lookup then completes normally.
